mtm_delay_arbiter: RTL

- Round-robin arbiter that shares one fixed-latency resource slot among NREQ requesters.
- Each grant holds the resource for a latency chosen at grant time from three elaboration-time corners (minimum, typical, maximum), selected by a runtime corner input.
- Sits in front of any shared unit whose occupancy time is characterised as a min:typ:max triple.
- Non-preemptive: one grant at a time.

---
 rtl/mtm_arb_pkg.sv | 33 +++
 rtl/mtm_delay_arbiter_rr_pick.sv | 31 +++
 rtl/mtm_delay_arbiter.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/mtm_arb_pkg.sv
// Shared types and helpers for mtm_delay_arbiter.
package mtm_arb_pkg;

  typedef enum logic [1:0] {
    CORNER_MIN  = 2'd0,
    CORNER_TYP  = 2'd1,
    CORNER_MAX  = 2'd2,
    CORNER_TYP2 = 2'd3
  } corner_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  localparam int unsigned STAT_W = 16;

  // Occupancy cycles for a corner; both TYP encodings map to the typical value.
  function automatic int unsigned corner_lat(input corner_e     corner,
                                             input int unsigned lat_min,
                                             input int unsigned lat_typ,
                                             input int unsigned lat_max);
    int unsigned lat;
    case (corner)
      CORNER_MIN: lat = lat_min;
      CORNER_MAX: lat = lat_max;
      default:    lat = lat_typ;
    endcase
    return lat;
  endfunction

endpackage

// File: rtl/mtm_delay_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request above ptr, wrapping.
module rr_pick #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned IW   = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic            valid_c,
  output logic [NREQ-1:0] onehot_c,
  output logic [IW-1:0]   idx_c
);

  logic [IW-1:0] cand;

  // Scan ptr+1 .. ptr+NREQ (mod NREQ) and keep the first hit.
  always_comb begin
    valid_c  = 1'b0;
    onehot_c = '0;
    idx_c    = '0;
    cand     = '0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand = IW'((32'(ptr) + k) % NREQ);
      if (!valid_c && req[cand]) begin
        valid_c = 1'b1;
        idx_c   = cand;
      end
    end
    if (valid_c) onehot_c = NREQ'(1) << idx_c;
  end

endmodule

// File: rtl/mtm_delay_arbiter.sv
// Non-preemptive round-robin arbiter with min:typ:max occupancy latency.
// Optional per-requester grant counters: define MTM_DELAY_ARBITER_STATS_EN.
module mtm_delay_arbiter
  import mtm_arb_pkg::*;
#(
  parameter int unsigned NREQ    = 4,
  parameter int unsigned LAT_MIN = 1,
  parameter int unsigned LAT_TYP = 2,
  parameter int unsigned LAT_MAX = 3,
  parameter int unsigned CW      = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [1:0]               corner_i,
  input  logic [NREQ-1:0]          req_i,
  output logic [NREQ-1:0]          gnt_o,
  output logic [NREQ-1:0]          done_o,
  output logic                     busy_o,
  output logic [CW-1:0]            lat_o,
  output logic [NREQ*STAT_W-1:0]   gnt_cnt_o
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  // Parameter sanity checks at elaboration.
  if (LAT_MIN == 0) begin : g_chk_min
    $error("mtm_delay_arbiter: LAT_MIN must be nonzero");
  end
  if ((LAT_MIN > LAT_TYP) || (LAT_TYP > LAT_MAX)) begin : g_chk_order
    $error("mtm_delay_arbiter: require LAT_MIN <= LAT_TYP <= LAT_MAX");
  end
  if (64'(LAT_MAX) >= (64'd1 << CW)) begin : g_chk_cw
    $error("mtm_delay_arbiter: LAT_MAX does not fit in CW bits");
  end
  if ((NREQ < 2) || (NREQ > 16)) begin : g_chk_nreq
    $error("mtm_delay_arbiter: NREQ must be 2..16");
  end

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]   win_q, win_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic [NREQ-1:0] done_q, done_d;
  logic            busy_q, busy_d;
  logic [CW-1:0]   lat_q, lat_d;

  logic            pick_valid;
  logic [NREQ-1:0] pick_onehot;
  logic [IW-1:0]   pick_idx;
  logic [CW-1:0]   lat_pick;
  logic            finish_c;

  rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .req      (req_i),
    .ptr      (rr_ptr_q),
    .valid_c  (pick_valid),
    .onehot_c (pick_onehot),
    .idx_c    (pick_idx)
  );

  assign lat_pick = CW'(corner_lat(corner_e'(corner_i), LAT_MIN, LAT_TYP, LAT_MAX));
  assign finish_c = (state_q == S_BUSY) && (cnt_q == '0);

  // Next-state and registered-output logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rr_ptr_d = rr_ptr_q;
    win_d    = win_q;
    gnt_d    = gnt_q;
    done_d   = '0;
    busy_d   = busy_q;
    lat_d    = lat_q;
    case (state_q)
      S_IDLE: begin
        gnt_d  = '0;
        busy_d = 1'b0;
        if (pick_valid) begin
          state_d = S_BUSY;
          win_d   = pick_idx;
          gnt_d   = pick_onehot;
          busy_d  = 1'b1;
          lat_d   = lat_pick;
          cnt_d   = lat_pick - CW'(1);
        end
      end
      S_BUSY: begin
        if (cnt_q == '0) begin
          state_d  = S_DONE;
          gnt_d    = '0;
          done_d   = gnt_q;
          rr_ptr_d = win_q;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        gnt_d   = '0;
        busy_d  = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
        gnt_d   = '0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      rr_ptr_q <= IW'(NREQ - 1);
      win_q    <= '0;
      gnt_q    <= '0;
      done_q   <= '0;
      busy_q   <= 1'b0;
      lat_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rr_ptr_q <= rr_ptr_d;
      win_q    <= win_d;
      gnt_q    <= gnt_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      lat_q    <= lat_d;
    end
  end

  assign gnt_o  = gnt_q;
  assign done_o = done_q;
  assign busy_o = busy_q;
  assign lat_o  = lat_q;

`ifdef MTM_DELAY_ARBITER_STATS_EN
  logic [STAT_W-1:0] stat_q [NREQ];
  logic [STAT_W-1:0] stat_d [NREQ];

  // Count completions per requester, saturating.
  always_comb begin
    stat_d = stat_q;
    if (finish_c && (stat_q[win_q] != {STAT_W{1'b1}})) begin
      stat_d[win_q] = stat_q[win_q] + STAT_W'(1);
    end
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NREQ); i++) stat_q[i] <= '0;
    end else begin
      stat_q <= stat_d;
    end
  end

  for (genvar g = 0; g < int'(NREQ); g++) begin : g_stat_out
    assign gnt_cnt_o[STAT_W*g +: STAT_W] = stat_q[g];
  end
`else
  logic unused_finish;
  assign unused_finish = finish_c;
  assign gnt_cnt_o     = '0;
`endif

endmodule
